// File: rtl/des_pkg.sv
// Shared DES constants and helpers: permutation tables, S-boxes, key-shift schedule,
// FSM state type, the f-function and (with DES_KEY_PARITY_EN) the key parity check.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Table entries are 1-based DES bit numbers, bit 1 being the MSB of the source word.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // One 256-bit word per S-box: four rows of sixteen nibbles, row 0 column 0 in the MSBs.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        logic [5:0] idx;
        idx = {b[5], b[0], b[4:1]};
        return SBOX[n][8'(255 - 4 * int'(idx)) -: 4];
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        x = x ^ k;
        for (int i = 0; i < 8; i++) s[5'(31 - 4 * i) -: 4] = sbox(3'(i), x[6'(47 - 6 * i) -: 6]);
        for (int i = 0; i < 32; i++) des_f[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right,
                                          input logic [1:0] amt);
        case (amt)
            2'd1:    return right ? {x[0], x[27:1]} : {x[26:0], x[27]};
            2'd2:    return right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

`ifdef DES_KEY_PARITY_EN
    // Every key byte must have odd parity; flag any byte that does not.
    function automatic logic key_parity_err(input logic [63:0] key);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) err = err | ~(^key[6'(8 * b) +: 8]);
        return err;
    endfunction
`endif

endpackage

// File: rtl/des_round_comb.sv
// One combinational DES round including the on-the-fly key-schedule rotation
// (left for encryption, right for decryption, none before decrypt round 0).
module des_round_comb
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic        decrypt,
    input  logic [3:0]  round,
    output logic [31:0] l_next,
    output logic [31:0] r_next,
    output logic [27:0] c_next,
    output logic [27:0] d_next
);

    logic [1:0] amt;

    always_comb begin
        if (!decrypt)
            amt = 2'(SHIFT[round]);
        else if (round == 4'd0)
            amt = 2'd0;
        else
            amt = 2'(SHIFT[4'(5'd16 - {1'b0, round})]);
        c_next = rot28(c, decrypt, amt);
        d_next = rot28(d, decrypt, amt);
        l_next = r;
        r_next = l ^ des_f(r, pc2({c_next, d_next}));
    end

endmodule

// File: rtl/des_iter_core.sv
// Iterative handshaked DES engine: ROUNDS_PER_CYCLE chained rounds per clock.
// Optional `DES_KEY_PARITY_EN adds out_key_err, an informational key-parity flag.
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_key,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
`ifdef DES_KEY_PARITY_EN
    output logic        out_key_err,
`endif
    output logic        busy
);

    localparam int RPC = ROUNDS_PER_CYCLE;
    // Counter value at the start of the cycle that finishes round 15.
    localparam logic [3:0] LAST_CNT = 4'(16 - RPC);

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q, l_end, r_end;
    logic [27:0] c_q, d_q, c_end, d_end;
    logic [3:0]  cnt_q;
    logic        dec_q;
    logic        accept;

    assign accept = in_valid && (state_q == IDLE);

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [31:0] l_i, r_i, l_o, r_o;
        logic [27:0] c_i, d_i, c_o, d_o;
        if (j == 0) begin : g_head
            assign {l_i, r_i, c_i, d_i} = {l_q, r_q, c_q, d_q};
        end else begin : g_link
            assign {l_i, r_i, c_i, d_i} =
                {g_round[j-1].l_o, g_round[j-1].r_o, g_round[j-1].c_o, g_round[j-1].d_o};
        end
        des_round_comb u_round (
            .l       (l_i),
            .r       (r_i),
            .c       (c_i),
            .d       (d_i),
            .decrypt (dec_q),
            .round   (cnt_q + 4'(j)),
            .l_next  (l_o),
            .r_next  (r_o),
            .c_next  (c_o),
            .d_next  (d_o)
        );
    end

    assign {l_end, r_end, c_end, d_end} =
        {g_round[RPC-1].l_o, g_round[RPC-1].r_o, g_round[RPC-1].c_o, g_round[RPC-1].d_o};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments, so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {l_q, r_q} <= '0;
            {c_q, d_q} <= '0;
            cnt_q      <= '0;
            dec_q      <= 1'b0;
            out_data   <= '0;
        end else if (accept) begin
            {l_q, r_q} <= ip(in_data);
            {c_q, d_q} <= pc1(in_key);
            dec_q      <= in_decrypt;
            cnt_q      <= '0;
        end else if (state_q == RUN) begin
            {l_q, r_q, c_q, d_q} <= {l_end, r_end, c_end, d_end};
            if (cnt_q == LAST_CNT) begin
                cnt_q    <= '0;
                out_data <= fp({r_end, l_end});
            end else begin
                cnt_q <= cnt_q + 4'(RPC);
            end
        end
    end

`ifdef DES_KEY_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_key_err <= 1'b0;
        else if (accept) out_key_err <= key_parity_err(in_key);
    end
`endif

endmodule
